// File: rtl/addr_bus_sequencer.sv
// Sequencer for the shared 16-bit address bus: arbitrates among counter/address
// registers, drives their active-low address enables and post-op inc/dec strobes.
module addr_bus_sequencer #(
    parameter int NREQ = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    output logic [NREQ-1:0]   a_addr_n,
    output logic [NREQ-1:0]   inc,
    output logic [NREQ-1:0]   dec,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_STEP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_RSV  = 2'b11
    } op_t;

    state_t          state, state_nxt;
    op_t             op_q, op_nxt;
    logic [IW-1:0]   win, win_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;

    logic [NREQ-1:0] arb_req;
    logic            arb_found;
    logic            arb_rr;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   cand;
    int              pos;

    // Requester 0 has fixed priority; 1..NREQ-1 rotate starting after ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        arb_req   = req;
        arb_found = 1'b0;
        arb_rr    = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        pos       = 0;
        if (state == S_DONE) arb_req[win] = 1'b0;
        if (arb_req[0]) begin
            arb_found = 1'b1;
        end else begin
            for (int k = 1; k < NREQ; k++) begin
                pos = int'(ptr) + k;
                if (pos > NREQ - 1) pos = pos - (NREQ - 1);
                cand = IW'(pos);
                if (!arb_found && arb_req[cand]) begin
                    arb_found = 1'b1;
                    arb_rr    = 1'b1;
                    arb_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        op_nxt    = op_q;
        ptr_nxt   = ptr;
        case (state)
            S_IDLE, S_DONE: begin
                if (arb_found) begin
                    state_nxt = S_ADDR;
                    win_nxt   = arb_idx;
                    op_nxt    = op_t'(op[2*arb_idx +: 2]);
                    if (arb_rr) ptr_nxt = arb_idx;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ADDR:  state_nxt = (op_q == OP_INC || op_q == OP_DEC) ? S_STEP : S_DONE;
            S_STEP:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and flopped, so they are glitch-free
    // and have no combinational path from req/op.
    logic [NREQ-1:0] onehot;
    logic [NREQ-1:0] a_addr_nxt, inc_nxt, dec_nxt, gnt_nxt, ack_nxt;

    always_comb begin
        onehot          = '0;
        onehot[win_nxt] = 1'b1;
        a_addr_nxt      = '1;
        inc_nxt         = '1;
        dec_nxt         = '1;
        gnt_nxt         = '0;
        ack_nxt         = '0;
        case (state_nxt)
            S_ADDR: begin
                a_addr_nxt = ~onehot;
                gnt_nxt    = onehot;
            end
            S_STEP: begin
                if (op_nxt == OP_INC)      inc_nxt = ~onehot;
                else if (op_nxt == OP_DEC) dec_nxt = ~onehot;
            end
            S_DONE:  ack_nxt = onehot;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= OP_NONE;
            win      <= '0;
            ptr      <= IW'(NREQ - 1);
            a_addr_n <= '1;
            inc      <= '1;
            dec      <= '1;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_q     <= op_nxt;
            win      <= win_nxt;
            ptr      <= ptr_nxt;
            a_addr_n <= a_addr_nxt;
            inc      <= inc_nxt;
            dec      <= dec_nxt;
            gnt      <= gnt_nxt;
            ack      <= ack_nxt;
            busy     <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_addr_bus_sequencer.sv
// Self-checking bench for addr_bus_sequencer (NREQ=4): per-cycle vector table
// plus hand-written sequences for reset, round-robin and multi-transaction cases.
module tb_addr_bus_sequencer;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic [7:0] op;
    logic [3:0] a_addr_n, inc, dec, gnt, ack;
    logic       busy;

    int errors = 0;
    int checks = 0;

    addr_bus_sequencer #(.NREQ(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .op       (op),
        .a_addr_n (a_addr_n),
        .inc      (inc),
        .dec      (dec),
        .gnt      (gnt),
        .ack      (ack),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model registers: each counts on a rising edge of its strobe outside reset.
    logic [3:0]  inc_prev = 4'hF;
    logic [3:0]  dec_prev = 4'hF;
    int unsigned inc_cnt[4] = '{default: 0};
    int unsigned dec_cnt[4] = '{default: 0};

    always @(inc or dec) begin
        for (int i = 0; i < 4; i++) begin
            if (reset_n && !inc_prev[i] && inc[i]) inc_cnt[i]++;
            if (reset_n && !dec_prev[i] && dec[i]) dec_cnt[i]++;
        end
        inc_prev = inc;
        dec_prev = dec;
    end

    function automatic logic [15:0] reg_val(input int i);
        return 16'hAAAA + 16'(inc_cnt[i]) - 16'(dec_cnt[i]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt != 4'h0) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic run_txn(input int idx, input logic [1:0] o, output int cyc, output logic strobe);
        req = '0;
        req[idx] = 1'b1;
        op = '0;
        op[2*idx +: 2] = o;
        cyc = 0;
        strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc++;
            if (inc != 4'hF || dec != 4'hF) strobe = 1'b1;
            if (ack[idx]) break;
        end
        req = '0;
        op  = '0;
        tick();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] op;
        logic [3:0] a_addr_n;
        logic [3:0] inc;
        logic [3:0] dec;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t       vecs[9];
    logic [3:0] exp_rr[7];
    logic [3:0] g;
    int         cyc;
    logic       strobe;

    initial begin
        // Single increment on requester 1, then priority 0 over 2 back-to-back.
        vecs[0] = '{4'b0010, 8'h04, 4'b1101, 4'hF,    4'hF, 4'b0010, 4'b0000, 1'b1};
        vecs[1] = '{4'b0010, 8'h04, 4'hF,    4'b1101, 4'hF, 4'b0000, 4'b0000, 1'b1};
        vecs[2] = '{4'b0010, 8'h04, 4'hF,    4'hF,    4'hF, 4'b0000, 4'b0010, 1'b1};
        vecs[3] = '{4'b0000, 8'h00, 4'hF,    4'hF,    4'hF, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{4'b0101, 8'h00, 4'b1110, 4'hF,    4'hF, 4'b0001, 4'b0000, 1'b1};
        vecs[5] = '{4'b0101, 8'h00, 4'hF,    4'hF,    4'hF, 4'b0000, 4'b0001, 1'b1};
        vecs[6] = '{4'b0100, 8'h00, 4'b1011, 4'hF,    4'hF, 4'b0100, 4'b0000, 1'b1};
        vecs[7] = '{4'b0100, 8'h00, 4'hF,    4'hF,    4'hF, 4'b0000, 4'b0100, 1'b1};
        vecs[8] = '{4'b0000, 8'h00, 4'hF,    4'hF,    4'hF, 4'b0000, 4'b0000, 1'b0};
        exp_rr  = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        req = '0;
        op = '0;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        req = 4'hF;
        tick();
        tick();
        check("rst_a_addr_n", a_addr_n, 4'hF);
        check("rst_inc", inc, 4'hF);
        check("rst_dec", dec, 4'hF);
        check("rst_gnt", gnt, 4'h0);
        check("rst_ack", ack, 4'h0);
        check("rst_busy", busy, 1'b0);

        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("first_gnt", gnt, 4'b0001);
        check("first_a_addr_n", a_addr_n, 4'b1110);
        req = '0;
        tick();
        check("first_ack", ack, 4'b0001);
        tick();
        check("first_idle", busy, 1'b0);

        // Round robin 1,2,3,1,2,3 then requester 0 jumps in.
        req = 4'b1110;
        for (int t = 0; t < 7; t++) begin
            wait_gnt(g);
            check($sformatf("rr_gnt%0d", t), g, exp_rr[t]);
            if (t == 5) req = 4'b1111;
            if (t == 6) req = 4'b0000;
        end
        tick();
        tick();
        check("rr_idle", busy, 1'b0);

        for (int v = 0; v < 9; v++) begin
            req = vecs[v].req;
            op  = vecs[v].op;
            tick();
            check($sformatf("v%0d_a_addr_n", v), a_addr_n, vecs[v].a_addr_n);
            check($sformatf("v%0d_inc", v), inc, vecs[v].inc);
            check($sformatf("v%0d_dec", v), dec, vecs[v].dec);
            check($sformatf("v%0d_gnt", v), gnt, vecs[v].gnt);
            check($sformatf("v%0d_ack", v), ack, vecs[v].ack);
            check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
        end
        check("reg1_after_inc", reg_val(1), 16'hAAAB);

        // Two decrements then a reserved op on requester 3.
        run_txn(3, 2'b10, cyc, strobe);
        check("dec1_cycles", cyc, 3);
        check("dec1_strobe", strobe, 1'b1);
        run_txn(3, 2'b10, cyc, strobe);
        check("dec2_cycles", cyc, 3);
        check("reg3_after_dec", reg_val(3), 16'hAAA8);
        run_txn(3, 2'b11, cyc, strobe);
        check("rsv_cycles", cyc, 2);
        check("rsv_strobe", strobe, 1'b0);
        check("reg3_after_rsv", reg_val(3), 16'hAAA8);

        // Reset during STEP of an increment, then a fresh transaction.
        req = 4'b0010;
        op  = 8'h04;
        tick();
        tick();
        check("mid_step_inc", inc, 4'b1101);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_inc", inc, 4'hF);
        check("mid_rst_dec", dec, 4'hF);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", ack, 4'h0);
        check("mid_rst_a_addr_n", a_addr_n, 4'hF);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post_rst_gnt", gnt, 4'b0010);
        tick();
        check("post_rst_inc", inc, 4'b1101);
        tick();
        check("post_rst_ack", ack, 4'b0010);
        req = '0;
        op  = '0;
        tick();
        check("post_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addr_bus_sequencer.md
# addr_bus_sequencer

Arbitrates and sequences access to the shared 16-bit address bus among up to eight CounterAddressRegister instances (PC, SP, SI, DI, …). Each requester asks for one address cycle with an optional post-increment or post-decrement. The block drives the registers' active-low address-assert enables and generates their rising-edge-active inc/dec strobes. It sits between the pipeline control logic and the register file, and is the only driver of those register control pins.

## Interface

Parameters:
- NREQ, 4, number of requesters/registers; legal range 2–8.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request; level, held until ack.
- op  in  2*NREQ  per-requester post-op, op[2i+1:2i]:
  - 00: none
  - 01: increment
  - 10: decrement
  - 11: reserved, treated as none
- a_addr_n  out  NREQ  active-low Addr-bus assert to register i.
- inc  out  NREQ  increment strobe to register i; idle high; the register counts on the low→high edge.
- dec  out  NREQ  decrement strobe to register i; same convention as inc.
- gnt  out  NREQ  one-hot; the winner during ADDR.
- ack  out  NREQ  one-cycle pulse to the winner in DONE.
- busy  out  1  high in any state other than IDLE.

## Operation

- States:
  - IDLE
  - ADDR: address cycle.
  - STEP: strobe low.
  - DONE: strobe released, ack.
- IDLE: if any req=1 at a clock edge, latch the winner index w and op[w], then go to ADDR. Otherwise stay in IDLE.
- ADDR: a_addr_n[w]=0 and gnt[w]=1. At the next edge, go to STEP if the latched op is inc or dec; otherwise go to DONE.
- STEP: inc[w]=0 (op 01) or dec[w]=0 (op 10); a_addr_n is all high. Next edge goes to DONE. The strobe returning high at that edge is the count edge.
- DONE: ack[w]=1. Arbitrate again among req with bit w masked:
  - any remaining request: latch the new winner and go to ADDR (no idle bubble);
  - none: go to IDLE.
- Arbitration: requester 0 (fetch) has fixed highest priority. Requesters 1..NREQ-1 are served round-robin from a pointer holding the last RR winner. The search starts at pointer+1, wraps, and skips index 0. The pointer updates only when an RR requester wins.
- Pointer reset value is NREQ-1, so requester 1 has the highest RR priority after reset.
- op is sampled only when the winner is latched. Later op changes are ignored for that transaction.
- Dropping req before ack does not abort the transaction; it completes with the latched op.
- All outputs are registered and glitch-free; decode is from state, w and op. No combinational path exists from req/op to any output.
- At most one bit of a_addr_n, inc, dec, gnt and ack is active at any time.
- inc and dec are never both active.

## Timing

- Reset (async assert) values:
  - state = IDLE
  - a_addr_n = all 1
  - inc = all 1
  - dec = all 1
  - gnt = 0
  - ack = 0
  - busy = 0
  - pointer = NREQ-1
- Reset during STEP forces the strobe high immediately. The resulting rising edge may count the register; the system clears registers concurrently with reset. No ack is issued for the interrupted transaction.
- Latency, with req sampled high at edge E0 in IDLE:
  - E0: ADDR
  - E1: STEP
  - E2: DONE (count edge, ack)
  - E3: next ADDR or IDLE
- Latency for op none:
  - E0: ADDR
  - E1: DONE
  - E2: next ADDR or IDLE
- Throughput under continuous requests: one transaction per 3 cycles, or per 2 cycles for op none.
- The requester must deassert req in the cycle after seeing ack. If req is still high at the edge after DONE while in IDLE, a new transaction starts.

## Test plan

- Reset: hold reset_n=0 with req=4'hF.
  - Outputs: a_addr_n=4'hF, inc=4'hF, dec=4'hF, gnt=0, ack=0, busy=0.
  - Release reset mid-cycle; the first grant is to requester 0.
- Single increment: req=4'b0010, op[3:2]=01, with a model register holding 0xAAAA.
  - One cycle of a_addr_n=4'b1101, then inc=4'b1101 for one cycle, then ack=4'b0010.
  - Register reads 0xAAAB.
- Priority and back-to-back: req=4'b0101 (op none for both).
  - gnt=0001 first; ack=0001 in the same cycle DONE transitions directly into gnt=0100.
  - No IDLE cycle between them.
- Round-robin: req=4'b1110 held, each requester re-asserting after ack, all op none.
  - Grant order is 1,2,3,1,2,3; requester 0 asserted mid-stream wins the next arbitration.
- Decrement and reserved op: requester 3 issues two transactions with op 10 from 0xAAAA.
  - Register reads 0xAAA8.
  - A third transaction with op 11 produces ADDR and DONE only: no strobe, value stays 0xAAA8.
- Reset mid-operation: assert reset_n=0 during STEP of an increment.
  - dec and inc all high asynchronously, busy=0, no ack.
  - After release with req held, a fresh transaction completes normally.
